ll_mem_responder: RTL
=====================

# ll_mem_responder

Lower-level memory responder that serves the cache-to-lower-level request/ready interface from the initiator side of an L1 cache. It accepts one read or write per transaction, services it from an internal word-addressed array after a fixed programmable latency, and returns a single-cycle ready pulse, with read data on reads. It sits below the L1 as the system's backing store and as the latency-modelling endpoint for cache verification.

## Interface
- DEPTH, 8192: number of 32-bit words in the array; power of two, ≥ 2.
- LATENCY, 4: cycles from request acceptance to ready pulse; ≥ 1.
- clock  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- addrToLl  input  32  byte address; word index = addrToLl[2+$clog2(DEPTH)-1:2]; bits [1:0] and upper bits are ignored, so the array aliases.
- enableToLl  input  1  request valid; held with addr/write/data until ready is seen.
- writeToLl  input  1  0 = read, 1 = write.
- dataToLl  input  32  write data.
- dataFromLl  output  32  read data, registered.
- readyFromLl  output  1  transaction-complete pulse, registered, exactly 1 cycle.
- rdCount, wrCount  output  32 each  present only with LL_MEM_STATS_EN.

## Operation
- FSM states: IDLE, BUSY, RESP, GAP.
- IDLE: if enableToLl=1, capture addr index, write, and data, then go to RESP if LATENCY=1, else BUSY with cnt=LATENCY-2.
- BUSY: when cnt=0, go to RESP; else decrement cnt. Inputs are ignored; captured values are used.
- Edge entering RESP: a write updates array[idx]; a read loads dataFromLl ← array[idx].
- RESP: readyFromLl=1 for this one cycle, then go to GAP.
- GAP: one cycle with enableToLl ignored, which absorbs an initiator that drops enable one cycle late. Then go to IDLE.
- In IDLE, a still-asserted enable is treated as a new transaction.
- dataFromLl holds the last read value through writes and idle cycles; a write never changes it.
- Read-after-write to the same index in the next transaction returns the new data.
- Only one transaction is outstanding; there is no queueing.

## Timing
- Reset values: readyFromLl=0, dataFromLl=0, state=IDLE, cnt=0, and rdCount/wrCount=0.
- The array is not reset and its contents survive reset.
- Acceptance edge k is the edge where IDLE samples enable=1.
- readyFromLl is high between edges k+LATENCY-1 and k+LATENCY.
- Minimum period between acceptances is LATENCY+2 cycles (through RESP and GAP).
- Reset during BUSY drops the transaction: no ready, and no array write.
- Reset during RESP: ready deasserts immediately. A write already committed at RESP entry stays committed.
- Changes on addr/data/write after acceptance have no effect.

## Configuration
- LL_MEM_STATS_EN defined:
  - rdCount/wrCount ports exist.
  - Each counter increments on the edge entering RESP for a read or write respectively.
  - Counters saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: the ports and counters are absent, and all other behaviour is identical.

## Structure
- Package ll_mem_pkg:
  - state enum typedef ll_mem_state_t {IDLE, BUSY, RESP, GAP}.
  - Constant LL_MEM_MIN_LATENCY = 1.
  - Counter saturation value.
- Sub-module ll_mem_array: single-port synchronous RAM with DEPTH×32, write enable, and registered read output. It contains no reset logic.
- ll_mem_responder holds the FSM, latency counter, capture registers, and optional stats.

## Test plan
- Reset, LATENCY=4: readyFromLl=0 and dataFromLl=0 during and after reset, until the first request.
- Write then read, LATENCY=4:
  - Write 32'hDEADBEEF to 32'h0000_0040 with acceptance at edge k; ready is high only in cycle k+3→k+4.
  - A subsequent read of 32'h0000_0040 returns 32'hDEADBEEF with its ready pulse.
- Enable held through ready (L1 style, read of 32'h80):
  - GAP ignores enable; a second transaction is accepted 2 cycles after ready.
  - Exactly 2 ready pulses in 2×(LATENCY+2) cycles.
- LATENCY=1, DEPTH=1024, aliasing:
  - Write 32'h1234_5678 to 32'h0000_0010, then read 32'h0000_1010; the read returns 32'h1234_5678 with ready one cycle after acceptance.
- Reset mid-BUSY:
  - Write 32'hA5A5A5A5 to 32'h20 over old data 32'h0, with reset asserted 1 cycle after acceptance.
  - No ready pulse; a later read of 32'h20 returns 32'h0.
- LL_MEM_STATS_EN: after 3 reads and 2 writes, rdCount=3 and wrCount=2; after reset, both read 0.

Source files
------------

// File: rtl/ll_mem_pkg.sv
// Shared types and constants for the lower-level memory responder.
// Holds the FSM state encoding, minimum latency and stats saturation value.
package ll_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    GAP
  } ll_mem_state_t;

  localparam int unsigned LL_MEM_MIN_LATENCY = 1;

  localparam logic [31:0] LL_MEM_CNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/ll_mem_array.sv
// Single-port DEPTHx32 synchronous RAM with registered read data (no reset).
// Ports: clock, i_we, i_re, i_addr, i_wdata in; o_rdata out (holds until next read).
module ll_mem_array #(
  parameter int unsigned DEPTH = 8192,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ll_mem_responder.sv
// Fixed-latency backing-store responder below an L1 (one outstanding request).
// Ports: clock, reset, addrToLl/enableToLl/writeToLl/dataToLl in;
// dataFromLl, readyFromLl out; rdCount/wrCount out with LL_MEM_STATS_EN.
module ll_mem_responder
  import ll_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 8192,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addrToLl,
  input  logic        enableToLl,
  input  logic        writeToLl,
  input  logic [31:0] dataToLl,
  output logic [31:0] dataFromLl,
  output logic        readyFromLl
`ifdef LL_MEM_STATS_EN
  ,
  output logic [31:0] rdCount,
  output logic [31:0] wrCount
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam int unsigned LD = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam bit          L1 = (LATENCY == LL_MEM_MIN_LATENCY);

  ll_mem_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic          r_wr;
  logic [31:0]   r_wdata;
  logic          r_rdy;
  logic          r_rd_seen;

  logic          w_idle_go;
  logic          w_busy_go;
  logic          w_commit;
  logic [AW-1:0] w_idx;
  logic          w_wr;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_unused = ^{addrToLl[31:AW+2], addrToLl[1:0]};

  // With single-cycle latency the array is hit straight from the inputs
  // on the acceptance edge; otherwise from the captured request.
  assign w_idle_go = L1 && (r_state == IDLE) && enableToLl;
  assign w_busy_go = (r_state == BUSY) && (r_cnt == '0);
  assign w_commit  = (w_idle_go || w_busy_go) && !reset;

  assign w_idx   = w_idle_go ? addrToLl[AW+1:2] : r_idx;
  assign w_wr    = w_idle_go ? writeToLl : r_wr;
  assign w_wdata = w_idle_go ? dataToLl : r_wdata;

  ll_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clock   (clock),
    .i_we    (w_commit && w_wr),
    .i_re    (w_commit && !w_wr),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_rdy     <= 1'b0;
      r_rd_seen <= 1'b0;
    end else begin
      if (w_commit && !w_wr) r_rd_seen <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (enableToLl) begin
            r_idx   <= addrToLl[AW+1:2];
            r_wr    <= writeToLl;
            r_wdata <= dataToLl;
            if (L1) begin
              r_state <= RESP;
              r_rdy   <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CW'(LD);
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            r_rdy   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          r_state <= GAP;
          r_rdy   <= 1'b0;
        end
        GAP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign readyFromLl = r_rdy;
  // The RAM output is not reset; mask it until the first read lands.
  assign dataFromLl  = r_rd_seen ? w_rdata : '0;

`ifdef LL_MEM_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_commit) begin
      if (!w_wr && r_rd_cnt != LL_MEM_CNT_SAT) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_wr && r_wr_cnt != LL_MEM_CNT_SAT) r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end

  assign rdCount = r_rd_cnt;
  assign wrCount = r_wr_cnt;
`endif

endmodule
